// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register: default widths and the
// two-bit state encoding used by the skid-buffer controller.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM handshake bundle: the upstream beat fields, the registered downstream
// fields and both valid/ready pairs. slave = pipeline register, master = its driver.
interface ex_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_W-1:0]  in_rd;
  logic              in_mem_rd;
  logic              in_mem_wr;
  logic              in_reg_wr;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_res;
  logic              out_zero;
  logic [DATA_W-1:0] out_wdata;
  logic [REG_W-1:0]  out_rd;
  logic              out_mem_rd;
  logic              out_mem_wr;
  logic              out_reg_wr;

  modport slave (
    input  in_valid, in_alu_res, in_wdata, in_rd, in_mem_rd, in_mem_wr, in_reg_wr,
    output in_ready,
    output out_valid, out_alu_res, out_zero, out_wdata, out_rd,
    output out_mem_rd, out_mem_wr, out_reg_wr,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu_res, in_wdata, in_rd, in_mem_rd, in_mem_wr, in_reg_wr,
    input  in_ready,
    input  out_valid, out_alu_res, out_zero, out_wdata, out_rd,
    input  out_mem_rd, out_mem_wr, out_reg_wr,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_entry.sv
// One register slot of the EX->MEM boundary: loads a whole beat when enabled and
// clears asynchronously on reset. Validity is tracked by the controller, not here.
module ex_mem_entry
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d_alu_res,
  input  logic              d_zero,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [REG_W-1:0]  d_rd,
  input  logic              d_mem_rd,
  input  logic              d_mem_wr,
  input  logic              d_reg_wr,
  output logic [DATA_W-1:0] q_alu_res,
  output logic              q_zero,
  output logic [DATA_W-1:0] q_wdata,
  output logic [REG_W-1:0]  q_rd,
  output logic              q_mem_rd,
  output logic              q_mem_wr,
  output logic              q_reg_wr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_alu_res <= '0;
      q_zero    <= 1'b0;
      q_wdata   <= '0;
      q_rd      <= '0;
      q_mem_rd  <= 1'b0;
      q_mem_wr  <= 1'b0;
      q_reg_wr  <= 1'b0;
    end else if (load) begin
      q_alu_res <= d_alu_res;
      q_zero    <= d_zero;
      q_wdata   <= d_wdata;
      q_rd      <= d_rd;
      q_mem_rd  <= d_mem_rd;
      q_mem_wr  <= d_mem_wr;
      q_reg_wr  <= d_reg_wr;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a one-entry skid buffer so that in_ready is a
// flop output and a MEM stall never reaches back into the ALU combinationally.
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  ex_mem_skid_reg_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic       in_ready_q;
  logic       main_load, skid_load, main_from_skid;
  logic       in_zero;

  logic [DATA_W-1:0] main_d_alu_res, main_d_wdata;
  logic [REG_W-1:0]  main_d_rd;
  logic              main_d_zero, main_d_mem_rd, main_d_mem_wr, main_d_reg_wr;

  logic [DATA_W-1:0] main_q_alu_res, main_q_wdata, skid_q_alu_res, skid_q_wdata;
  logic [REG_W-1:0]  main_q_rd, skid_q_rd;
  logic              main_q_zero, main_q_mem_rd, main_q_mem_wr, main_q_reg_wr;
  logic              skid_q_zero, skid_q_mem_rd, skid_q_mem_wr, skid_q_reg_wr;

  // Zero flag is taken from the ALU result at capture and travels with the beat.
  assign in_zero = (bus.in_alu_res == '0);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            main_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (bus.in_valid) main_load = 1'b1;
            else              state_d   = ST_EMPTY;
          end else if (bus.in_valid) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end
        end
        ST_SKID: begin
          if (bus.out_ready) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    if (main_from_skid) begin
      main_d_alu_res = skid_q_alu_res;
      main_d_zero    = skid_q_zero;
      main_d_wdata   = skid_q_wdata;
      main_d_rd      = skid_q_rd;
      main_d_mem_rd  = skid_q_mem_rd;
      main_d_mem_wr  = skid_q_mem_wr;
      main_d_reg_wr  = skid_q_reg_wr;
    end else begin
      main_d_alu_res = bus.in_alu_res;
      main_d_zero    = in_zero;
      main_d_wdata   = bus.in_wdata;
      main_d_rd      = bus.in_rd;
      main_d_mem_rd  = bus.in_mem_rd;
      main_d_mem_wr  = bus.in_mem_wr;
      main_d_reg_wr  = bus.in_reg_wr;
    end
  end

  // in_ready is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  ex_mem_entry #(.DATA_W(DATA_W), .REG_W(REG_W)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .d_alu_res (main_d_alu_res),
    .d_zero    (main_d_zero),
    .d_wdata   (main_d_wdata),
    .d_rd      (main_d_rd),
    .d_mem_rd  (main_d_mem_rd),
    .d_mem_wr  (main_d_mem_wr),
    .d_reg_wr  (main_d_reg_wr),
    .q_alu_res (main_q_alu_res),
    .q_zero    (main_q_zero),
    .q_wdata   (main_q_wdata),
    .q_rd      (main_q_rd),
    .q_mem_rd  (main_q_mem_rd),
    .q_mem_wr  (main_q_mem_wr),
    .q_reg_wr  (main_q_reg_wr)
  );

  ex_mem_entry #(.DATA_W(DATA_W), .REG_W(REG_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .d_alu_res (bus.in_alu_res),
    .d_zero    (in_zero),
    .d_wdata   (bus.in_wdata),
    .d_rd      (bus.in_rd),
    .d_mem_rd  (bus.in_mem_rd),
    .d_mem_wr  (bus.in_mem_wr),
    .d_reg_wr  (bus.in_reg_wr),
    .q_alu_res (skid_q_alu_res),
    .q_zero    (skid_q_zero),
    .q_wdata   (skid_q_wdata),
    .q_rd      (skid_q_rd),
    .q_mem_rd  (skid_q_mem_rd),
    .q_mem_wr  (skid_q_mem_wr),
    .q_reg_wr  (skid_q_reg_wr)
  );

  // Controls are gated by out_valid so a bubble can never store or write back.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_alu_res = main_q_alu_res;
  assign bus.out_zero    = main_q_zero;
  assign bus.out_wdata   = main_q_wdata;
  assign bus.out_rd      = main_q_rd;
  assign bus.out_mem_rd  = main_q_mem_rd & bus.out_valid;
  assign bus.out_mem_wr  = main_q_mem_wr & bus.out_valid;
  assign bus.out_reg_wr  = main_q_reg_wr & bus.out_valid;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed plus random bench for ex_mem_skid_reg, checked against a two-deep
// FIFO reference model of the pipeline register.
module tb_ex_mem_skid_reg;

  typedef struct {
    logic [31:0] alu_res;
    logic        zero;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;
  beat_t model_q[$];

  ex_mem_skid_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_mem_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input bit mrd, input bit mwr, input bit rwr,
                               input bit ordy, input bit fl);
    bus.in_valid   = v;
    bus.in_alu_res = alu;
    bus.in_wdata   = wd;
    bus.in_rd      = rd;
    bus.in_mem_rd  = mrd;
    bus.in_mem_wr  = mwr;
    bus.in_reg_wr  = rwr;
    bus.out_ready  = ordy;
    flush          = fl;
  endtask

  task automatic checkOutput();
    checkEq("out_valid", {31'd0, bus.out_valid}, {31'd0, model_q.size() > 0});
    checkEq("in_ready", {31'd0, bus.in_ready}, {31'd0, model_q.size() < 2});
    if (model_q.size() > 0) begin
      checkEq("out_alu_res", bus.out_alu_res, model_q[0].alu_res);
      checkEq("out_zero", {31'd0, bus.out_zero}, {31'd0, model_q[0].zero});
      checkEq("out_wdata", bus.out_wdata, model_q[0].wdata);
      checkEq("out_rd", {27'd0, bus.out_rd}, {27'd0, model_q[0].rd});
      checkEq("out_mem_rd", {31'd0, bus.out_mem_rd}, {31'd0, model_q[0].mem_rd});
      checkEq("out_mem_wr", {31'd0, bus.out_mem_wr}, {31'd0, model_q[0].mem_wr});
      checkEq("out_reg_wr", {31'd0, bus.out_reg_wr}, {31'd0, model_q[0].reg_wr});
    end else begin
      checkEq("bubble_ctrl", {29'd0, bus.out_mem_rd, bus.out_mem_wr, bus.out_reg_wr}, 32'd0);
    end
  endtask

  // Check current outputs, advance the FIFO model by one clock, then cross the edge.
  task automatic step();
    beat_t b;
    bit    can_push;
    bit    do_pop;
    checkOutput();
    can_push = bus.in_valid && (model_q.size() < 2);
    do_pop   = (model_q.size() > 0) && bus.out_ready;
    b.alu_res = bus.in_alu_res;
    b.zero    = (bus.in_alu_res == 32'd0);
    b.wdata   = bus.in_wdata;
    b.rd      = bus.in_rd;
    b.mem_rd  = bus.in_mem_rd;
    b.mem_wr  = bus.in_mem_wr;
    b.reg_wr  = bus.in_reg_wr;
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (can_push) model_q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b1);
    #12;
    checkEq("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkEq("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkEq("reset_alu_res", bus.out_alu_res, 32'd0);
    checkEq("reset_zero", {31'd0, bus.out_zero}, 32'd0);
    checkEq("reset_wdata", bus.out_wdata, 32'd0);
    checkEq("reset_rd", {27'd0, bus.out_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat");
    applyStimulus(1'b1, 32'h0000_00F0, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    idle(1'b1);
    checkEq("single_alu_res", bus.out_alu_res, 32'h0000_00F0);
    checkEq("single_zero", {31'd0, bus.out_zero}, 32'd0);
    checkEq("single_rd", {27'd0, bus.out_rd}, 32'd5);
    step();
    checkEq("single_drained", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] zero flag");
    applyStimulus(1'b1, 32'h0000_0000, 32'h1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h2, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkEq("zero_set", {31'd0, bus.out_zero}, 32'd1);
    step();
    idle(1'b1);
    checkEq("zero_clear", {31'd0, bus.out_zero}, 32'd0);
    step();

    $display("[TB] stall and skid");
    applyStimulus(1'b1, 32'h11, 32'hA, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h22, 32'hB, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle(1'b0);
    checkEq("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    step();
    idle(1'b1);
    checkEq("stall_first_A", bus.out_alu_res, 32'h11);
    step();
    checkEq("stall_then_B", bus.out_alu_res, 32'h22);
    checkEq("stall_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    step();

    $display("[TB] streaming");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h100 + i, 32'h200 + i, 5'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    idle(1'b1);
    step();
    step();

    $display("[TB] flush in skid");
    applyStimulus(1'b1, 32'h44, 32'h4, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h55, 32'h5, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h33, 32'h3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    idle(1'b1);
    checkEq("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    step();

    $display("[TB] async reset while full");
    applyStimulus(1'b1, 32'h66, 32'h6, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    idle(1'b0);
    checkEq("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkEq("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkEq("async_ctrl", {29'd0, bus.out_mem_rd, bus.out_mem_wr, bus.out_reg_wr}, 32'd0);
    #1 rst_n = 1'b1;
    model_q.delete();
    #1;
    checkEq("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic [31:0] alu;
      alu = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus(1'($urandom_range(0, 1)), alu, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 24) == 0));
      step();
    end
    idle(1'b1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
